// File: rtl/branch_pc_sequencer_if.sv
// Branch request handshake from decode plus the operand/result path to the
// shared branch-target adder.
interface branch_pc_sequencer_if;
  logic        br_valid;
  logic        br_ready;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_imm32;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic [31:0] adder_result;

  // Requester side: decode plus the external adder.
  modport master (
    output br_valid, br_taken, br_pc, br_imm32, adder_result,
    input  br_ready, adder_a, adder_b
  );

  modport slave (
    input  br_valid, br_taken, br_pc, br_imm32, adder_result,
    output br_ready, adder_a, adder_b
  );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential advance, taken-branch resolution through the
// shared adder, then a redirect window with flush asserted.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  branch_pc_sequencer_if.slave        bif,
  output logic [31:0]                 pc,
  output logic                        pc_valid,
  output logic                        flush,
  output logic [15:0]                 taken_count,
  output logic                        misalign_err
);

  typedef enum logic [1:0] {FETCH, RESOLVE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] adder_a_q, adder_a_d;
  logic [31:0] adder_b_q, adder_b_d;
  logic [15:0] taken_count_q, taken_count_d;
  logic        misalign_q, misalign_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      taken_count_q <= '0;
      misalign_q    <= 1'b0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      taken_count_q <= taken_count_d;
      misalign_q    <= misalign_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    adder_a_d     = adder_a_q;
    adder_b_d     = adder_b_q;
    taken_count_d = taken_count_q;
    misalign_d    = misalign_q;
    flush_cnt_d   = flush_cnt_q;

    unique case (state_q)
      FETCH: begin
        // A taken branch wins over stall and freezes the PC until redirect.
        if (bif.br_valid && bif.br_taken) begin
          adder_a_d = bif.br_pc + 32'd4;
          adder_b_d = bif.br_imm32 << 2;
          if (taken_count_q != 16'hFFFF) taken_count_d = taken_count_q + 16'd1;
          state_d = RESOLVE;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      RESOLVE: begin
        pc_d        = {bif.adder_result[31:2], 2'b00};
        misalign_d  = misalign_q | (bif.adder_result[1:0] != 2'b00);
        flush_cnt_d = 4'(FLUSH_CYCLES);
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        if (!stall) begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = '0;
            state_d     = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign bif.br_ready  = (state_q == FETCH);
  assign bif.adder_a   = adder_a_q;
  assign bif.adder_b   = adder_b_q;
  assign pc            = pc_q;
  assign pc_valid      = (state_q == FETCH) && !stall && !reset;
  assign flush         = (state_q != FETCH);
  assign taken_count   = taken_count_q;
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench: one DUT with a single flush cycle at reset PC 0, a second
// with two flush cycles starting near the top of the address space.
module tb_branch_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        stall, stall2;
  logic [31:0] pc, pc2;
  logic        pc_valid, pc_valid2;
  logic        flush, flush2;
  logic [15:0] taken_count, taken_count2;
  logic        misalign_err, misalign_err2;
  logic        force_en;
  logic [31:0] force_val;
  int          tests_run = 0;
  int          tests_failed = 0;

  branch_pc_sequencer_if bif ();
  branch_pc_sequencer_if bif2 ();

  always #5 clk = ~clk;

  // External adder: a plain sum, optionally overridden to inject a bad target.
  assign bif.adder_result  = force_en ? force_val : (bif.adder_a + bif.adder_b);
  assign bif2.adder_result = bif2.adder_a + bif2.adder_b;

  branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .bif(bif.slave),
    .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .taken_count(taken_count), .misalign_err(misalign_err)
  );

  branch_pc_sequencer #(.RESET_PC(32'hFFFF_FFF0), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .bif(bif2.slave),
    .pc(pc2), .pc_valid(pc_valid2), .flush(flush2),
    .taken_count(taken_count2), .misalign_err(misalign_err2)
  );

  task automatic drive_br(input logic v, input logic t, input logic [31:0] bpc, input logic [31:0] imm);
    bif.br_valid = v; bif.br_taken = t; bif.br_pc = bpc; bif.br_imm32 = imm;
  endtask

  task automatic test_reset;
    #12;
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
    tests_run++; if (pc_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_pc_valid got %b exp 0", pc_valid); end
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL rst_flush got %b exp 0", flush); end
    tests_run++; if (taken_count !== 16'h0) begin tests_failed++; $display("FAIL rst_taken got %h exp 0", taken_count); end
    tests_run++; if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
    tests_run++; if (bif.adder_a !== 32'h0 || bif.adder_b !== 32'h0) begin tests_failed++; $display("FAIL rst_adder got %h/%h exp 0/0", bif.adder_a, bif.adder_b); end
  endtask

  task automatic test_sequential;
    @(negedge clk); reset = 1'b0; #1;
    tests_run++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_first got %h/%b exp 00000000/1", pc, pc_valid); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if (pc !== 32'(i * 4) || pc_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_pc%0d got %h/%b exp %h/1", i, pc, pc_valid, 32'(i * 4)); end
    end
  endtask

  task automatic test_taken_forward;
    @(negedge clk);
    tests_run++; if (pc !== 32'h10) begin tests_failed++; $display("FAIL fwd_start_pc got %h exp 00000010", pc); end
    drive_br(1'b1, 1'b1, 32'h10, 32'd5); #1;
    tests_run++; if (bif.br_ready !== 1'b1) begin tests_failed++; $display("FAIL fwd_ready got %b exp 1", bif.br_ready); end
    @(negedge clk);
    tests_run++; if (bif.adder_a !== 32'h14 || bif.adder_b !== 32'h14) begin tests_failed++; $display("FAIL fwd_operands got %h/%h exp 00000014/00000014", bif.adder_a, bif.adder_b); end
    tests_run++; if (flush !== 1'b1 || pc_valid !== 1'b0 || bif.br_ready !== 1'b0) begin tests_failed++; $display("FAIL fwd_resolve_ctl got f%b v%b r%b exp f1 v0 r0", flush, pc_valid, bif.br_ready); end
    tests_run++; if (pc !== 32'h10 || taken_count !== 16'd1) begin tests_failed++; $display("FAIL fwd_resolve_pc got %h/%0d exp 00000010/1", pc, taken_count); end
    drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tests_run++; if (flush !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h28) begin tests_failed++; $display("FAIL fwd_redirect got f%b v%b pc %h exp f1 v0 pc 00000028", flush, pc_valid, pc); end
    @(negedge clk);
    tests_run++; if (flush !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h28 || taken_count !== 16'd1) begin tests_failed++; $display("FAIL fwd_target got f%b v%b pc %h cnt %0d exp f0 v1 pc 00000028 cnt 1", flush, pc_valid, pc, taken_count); end
  endtask

  task automatic test_taken_backward;
    drive_br(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFE);
    @(negedge clk);
    tests_run++; if (bif.adder_a !== 32'h44 || bif.adder_b !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL bwd_operands got %h/%h exp 00000044/fffffff8", bif.adder_a, bif.adder_b); end
    tests_run++; if (flush !== 1'b1 || taken_count !== 16'd2) begin tests_failed++; $display("FAIL bwd_resolve got f%b cnt %0d exp f1 cnt 2", flush, taken_count); end
    // A different request held while not ready must be ignored.
    drive_br(1'b1, 1'b1, 32'h80, 32'h1);
    @(negedge clk);
    tests_run++; if (pc !== 32'h3C || flush !== 1'b1 || bif.adder_a !== 32'h44 || taken_count !== 16'd2) begin tests_failed++; $display("FAIL bwd_redirect got pc %h f%b a %h cnt %0d exp 0000003c f1 00000044 2", pc, flush, bif.adder_a, taken_count); end
    drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tests_run++; if (pc !== 32'h3C || pc_valid !== 1'b1 || flush !== 1'b0) begin tests_failed++; $display("FAIL bwd_target got pc %h v%b f%b exp 0000003c v1 f0", pc, pc_valid, flush); end
  endtask

  task automatic test_not_taken;
    drive_br(1'b1, 1'b1, 32'h0, 32'd7);
    @(negedge clk); drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (pc !== 32'h20 || taken_count !== 16'd3) begin tests_failed++; $display("FAIL nt_setup got pc %h cnt %0d exp 00000020 3", pc, taken_count); end
    drive_br(1'b1, 1'b0, 32'h20, 32'h100); #1;
    tests_run++; if (bif.br_ready !== 1'b1) begin tests_failed++; $display("FAIL nt_ready got %b exp 1", bif.br_ready); end
    @(negedge clk);
    tests_run++; if (pc !== 32'h24 || flush !== 1'b0 || taken_count !== 16'd3) begin tests_failed++; $display("FAIL nt_pc1 got pc %h f%b cnt %0d exp 00000024 f0 3", pc, flush, taken_count); end
    drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tests_run++; if (pc !== 32'h28 || flush !== 1'b0 || pc_valid !== 1'b1) begin tests_failed++; $display("FAIL nt_pc2 got pc %h f%b v%b exp 00000028 f0 v1", pc, flush, pc_valid); end
  endtask

  task automatic test_misalign;
    force_val = 32'h31; force_en = 1'b1;
    drive_br(1'b1, 1'b1, 32'h0, 32'h0);
    @(negedge clk); drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tests_run++; if (pc !== 32'h30 || misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_redirect got pc %h err %b exp 00000030 1", pc, misalign_err); end
    force_en = 1'b0;
    @(negedge clk);
    tests_run++; if (pc !== 32'h30 || pc_valid !== 1'b1 || misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_target got pc %h v%b err %b exp 00000030 v1 1", pc, pc_valid, misalign_err); end
    drive_br(1'b1, 1'b1, 32'h30, 32'd2);
    @(negedge clk); drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (pc !== 32'h3C || misalign_err !== 1'b1 || taken_count !== 16'd5) begin tests_failed++; $display("FAIL mis_sticky got pc %h err %b cnt %0d exp 0000003c 1 5", pc, misalign_err, taken_count); end
  endtask

  task automatic test_reset_mid_resolve;
    drive_br(1'b1, 1'b1, 32'h0, 32'd1);
    @(negedge clk); drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL rr_in_resolve got f%b exp 1", flush); end
    reset = 1'b1; #1;
    tests_run++; if (pc !== 32'h0 || flush !== 1'b0 || misalign_err !== 1'b0 || pc_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_async got pc %h f%b err %b v%b exp 00000000 f0 0 v0", pc, flush, misalign_err, pc_valid); end
    tests_run++; if (taken_count !== 16'd0 || bif.adder_a !== 32'h0) begin tests_failed++; $display("FAIL rr_clear got cnt %0d a %h exp 0 00000000", taken_count, bif.adder_a); end
    @(negedge clk); reset = 1'b0; #1;
    tests_run++; if (pc !== 32'h0 || pc_valid !== 1'b1 || bif.br_ready !== 1'b1) begin tests_failed++; $display("FAIL rr_release got pc %h v%b r%b exp 00000000 v1 r1", pc, pc_valid, bif.br_ready); end
  endtask

  task automatic test_wrap_and_stall;
    @(negedge clk); reset2 = 1'b0; #1;
    tests_run++; if (pc2 !== 32'hFFFF_FFF0 || pc_valid2 !== 1'b1) begin tests_failed++; $display("FAIL wrap_start got %h/%b exp fffffff0/1", pc2, pc_valid2); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    tests_run++; if (pc2 !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_top got %h exp fffffffc", pc2); end
    @(negedge clk);
    tests_run++; if (pc2 !== 32'h0) begin tests_failed++; $display("FAIL wrap_zero got %h exp 00000000", pc2); end
    stall2 = 1'b1;
    bif2.br_valid = 1'b1; bif2.br_taken = 1'b1; bif2.br_pc = 32'h100; bif2.br_imm32 = 32'd4; #1;
    tests_run++; if (pc_valid2 !== 1'b0 || bif2.br_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_accept got v%b r%b exp v0 r1", pc_valid2, bif2.br_ready); end
    @(negedge clk);
    tests_run++; if (pc2 !== 32'h0 || bif2.adder_a !== 32'h104 || bif2.adder_b !== 32'h10 || taken_count2 !== 16'd1 || flush2 !== 1'b1) begin tests_failed++; $display("FAIL stall_resolve got pc %h a %h b %h cnt %0d f%b exp 00000000 00000104 00000010 1 f1", pc2, bif2.adder_a, bif2.adder_b, taken_count2, flush2); end
    bif2.br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (pc2 !== 32'h114 || flush2 !== 1'b1 || pc_valid2 !== 1'b0) begin tests_failed++; $display("FAIL stall_hold%0d got pc %h f%b v%b exp 00000114 f1 v0", i, pc2, flush2, pc_valid2); end
    end
    stall2 = 1'b0; #1;
    tests_run++; if (flush2 !== 1'b1) begin tests_failed++; $display("FAIL stall_drop got f%b exp 1", flush2); end
    @(negedge clk);
    tests_run++; if (flush2 !== 1'b1 || pc_valid2 !== 1'b0) begin tests_failed++; $display("FAIL stall_last got f%b v%b exp f1 v0", flush2, pc_valid2); end
    @(negedge clk);
    tests_run++; if (flush2 !== 1'b0 || pc_valid2 !== 1'b1 || pc2 !== 32'h114) begin tests_failed++; $display("FAIL stall_target got f%b v%b pc %h exp f0 v1 00000114", flush2, pc_valid2, pc2); end
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; stall = 1'b0; stall2 = 1'b0;
    force_en = 1'b0; force_val = 32'h0;
    drive_br(1'b0, 1'b0, 32'h0, 32'h0);
    bif2.br_valid = 1'b0; bif2.br_taken = 1'b0; bif2.br_pc = 32'h0; bif2.br_imm32 = 32'h0;
    test_reset();
    test_sequential();
    test_taken_forward();
    test_taken_backward();
    test_not_taken();
    test_misalign();
    test_reset_mid_resolve();
    test_wrap_and_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
Owns the fetch PC and schedules the shared branch-target adder. It advances the PC sequentially and accepts taken/not-taken branch requests from decode over a valid/ready handshake. For a taken branch it drives the adder operands, captures the target, redirects the PC and flushes the pipeline for a configurable number of cycles.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FLUSH_CYCLES, 1, number of REDIRECT cycles with flush asserted (valid range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  freeze sequential PC advance
br_valid  in  1  branch request present
br_ready  out  1  controller accepts a request this cycle
br_taken  in  1  request is a taken branch
br_pc  in  32  PC of the branch instruction
br_imm32  in  32  sign-extended word offset
adder_a  out  32  operand A to the branch adder
adder_b  out  32  operand B to the branch adder
adder_result  in  32  sum returned by the branch adder (combinational)
pc  out  32  current fetch PC
pc_valid  out  1  pc is a valid fetch this cycle
flush  out  1  kill younger instructions
taken_count  out  16  saturating count of accepted taken branches
misalign_err  out  1  sticky: a target had bits [1:0] != 0

Behaviour:
- Reset (asynchronous): state=FETCH, pc=RESET_PC, adder_a=0, adder_b=0, taken_count=0, misalign_err=0, flush=0. pc_valid=0 while reset is high.
- States: FETCH, RESOLVE, REDIRECT.
- Outputs are registered, except br_ready, pc_valid and flush, which are decoded from the state.
- FETCH:
  - br_ready=1, flush=0, pc_valid=!stall.
  - If !stall, pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- FETCH, accepting a request (br_valid & br_ready):
  - Not-taken: no effect; pc advances as usual.
  - Taken: latch adder_a <= br_pc+4 and adder_b <= br_imm32<<2, discarding the upper 2 bits; taken_count++ (saturates at 0xFFFF); pc holds regardless of stall; next state RESOLVE.
- RESOLVE:
  - br_ready=0, pc_valid=0, flush=1.
  - adder_a and adder_b are held stable.
  - At the clock edge: pc <= {adder_result[31:2],2'b00}; misalign_err |= (adder_result[1:0]!=0); flush counter <= FLUSH_CYCLES; next state REDIRECT.
- REDIRECT:
  - br_ready=0, pc_valid=0, flush=1.
  - The counter decrements each cycle stall=0 and freezes while stall=1.
  - Counter reaching 0 moves to FETCH. The first FETCH cycle presents the target with pc_valid=!stall.
- Handshake rules:
  - While br_ready=0, br_valid is ignored; the requester holds its request until accepted.
  - br_taken, br_pc and br_imm32 are sampled only on the acceptance cycle.
- Simultaneous stall and taken request in FETCH: the request is accepted and stall does not block it.
- Taken-branch penalty with stall=0: 1 (RESOLVE) + FLUSH_CYCLES cycles from acceptance to the target fetch.
- Reset asserted mid-RESOLVE or mid-REDIRECT: all state is discarded immediately; the controller returns to FETCH at RESET_PC and misalign_err is cleared.

Test Plan:
1. Reset release, stall=0, no requests -> pc 0x0,0x4,0x8,0xC on consecutive cycles; pc_valid=1 from the first cycle after reset deasserts.
2. In FETCH at pc=0x10: br_valid=1, br_taken=1, br_pc=0x10, br_imm32=5 ->
   - next cycle RESOLVE with adder_a=0x14, adder_b=0x14, flush=1;
   - adder returns 0x28 -> one REDIRECT cycle;
   - then pc=0x28, pc_valid=1; taken_count=1.
3. Backward branch: br_pc=0x40, br_imm32=0xFFFF_FFFE -> adder_b=0xFFFF_FFF8, target pc=0x3C; penalty of 2 cycles with FLUSH_CYCLES=1.
4. Not-taken request (br_taken=0) at pc=0x20 -> pc continues 0x24,0x28; flush never asserts; taken_count unchanged.
5. Edge cases:
   - stall=1 held through REDIRECT (FLUSH_CYCLES=2) -> flush stays 1 and pc holds target until stall drops, then two more flush cycles.
   - pc=0xFFFF_FFFC with stall=0 -> next pc=0x0.
6. Fault and reset:
   - adder_result forced to 0x31 -> pc=0x30 and misalign_err=1, staying 1 through later branches.
   - reset pulsed during RESOLVE -> pc=RESET_PC, flush=0 and misalign_err=0 immediately.
